// File: rtl/ahb_rsa2048_slave.sv
// AHB-Lite slave computing R = M^E mod N on 2048-bit operands with a bit-serial
// interleaved modular multiplier running in the background of zero-wait bus accesses.
module ahb_rsa2048_slave #(
  parameter int ADDR_BITS = 12
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        sHSEL,
  input  logic [31:0] sHADDR,
  input  logic [1:0]  sHTRANS,
  input  logic        sHWRITE,
  input  logic [2:0]  sHSIZE,
  input  logic [2:0]  sHBURST,
  input  logic [31:0] sHWDATA,
  output logic [31:0] sHRDATA,
  output logic [1:0]  sHRESP,
  input  logic        sHREADYin,
  output logic        sHREADYout
);

  localparam int W  = 2048;
  localparam int PW = 2050;
  localparam logic [31:0] ID_VALUE = 32'h5253_4132;

  typedef enum logic [2:0] {ST_IDLE, ST_SCAN, ST_SQR, ST_MUL, ST_FINISH} state_t;

  state_t state, state_nxt;

  logic                 dp_valid;
  logic                 dp_write;
  logic [ADDR_BITS-3:0] dp_addr;
  logic [5:0]           idx;
  logic [3:0]           region;

  logic [63:0][31:0] m_mem, e_mem, n_mem, r_mem;
  logic              done_flag;
  logic              busy;
  logic              start_req;

  logic [W-1:0]  op_m, op_e, op_n, acc;
  logic [PW-1:0] prod, mm_next;
  logic [10:0]   bit_idx, it_idx;
  logic          fin;

  logic unused_ok;
  assign unused_ok = &{1'b0, sHADDR[31:ADDR_BITS], sHADDR[1:0], sHTRANS[0],
                       sHSIZE, sHBURST, prod[PW-1]};

  assign sHRESP     = 2'b00;
  assign sHREADYout = 1'b1;

  assign idx       = dp_addr[5:0];
  assign region    = dp_addr[9:6];
  assign start_req = dp_valid && dp_write && (dp_addr == '0) && sHWDATA[0] && (state == ST_IDLE);

  // One interleaved step: P = 2P + a*B, then bring back below N with at most two subtractions.
  function automatic logic [PW-1:0] mod_step(input logic [PW-2:0] p, input logic [W-1:0] b,
                                             input logic [W-1:0] n, input logic abit);
    logic [PW-1:0] t, nn;
    nn = {2'b00, n};
    t  = {p, 1'b0} + (abit ? {2'b00, b} : '0);
    if (t >= nn) t = t - nn;
    if (t >= nn) t = t - nn;
    return t;
  endfunction

  assign mm_next = mod_step(prod[PW-2:0], (state == ST_MUL) ? op_m : acc, op_n, acc[it_idx]);

  // Address phase capture and data-phase writes to the operand windows
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid <= 1'b0;
      dp_write <= 1'b0;
      dp_addr  <= '0;
      m_mem    <= '0;
      e_mem    <= '0;
      n_mem    <= '0;
    end else begin
      dp_valid <= sHSEL && sHTRANS[1] && sHREADYin;
      if (sHSEL && sHTRANS[1] && sHREADYin) begin
        dp_write <= sHWRITE;
        dp_addr  <= sHADDR[ADDR_BITS-1:2];
      end
      if (dp_valid && dp_write && !busy) begin
        case (region)
          4'h1:    m_mem[idx] <= sHWDATA;
          4'h2:    e_mem[idx] <= sHWDATA;
          4'h3:    n_mem[idx] <= sHWDATA;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (start_req) state_nxt = ST_SCAN;
      ST_SCAN: begin
        if (op_e[bit_idx])        state_nxt = ST_SQR;
        else if (bit_idx == '0)   state_nxt = ST_FINISH;
      end
      ST_SQR: begin
        if (fin) begin
          if (op_e[bit_idx])      state_nxt = ST_MUL;
          else if (bit_idx == '0) state_nxt = ST_FINISH;
        end
      end
      ST_MUL: if (fin) state_nxt = (bit_idx == '0) ? ST_FINISH : ST_SQR;
      ST_FINISH: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state != ST_IDLE);
    sHRDATA = '0;
    if (dp_valid && !dp_write) begin
      case (region)
        4'h0: begin
          if (idx == 6'd1)      sHRDATA = {30'd0, done_flag, busy};
          else if (idx == 6'd3) sHRDATA = ID_VALUE;
        end
        4'h1:    sHRDATA = m_mem[idx];
        4'h2:    sHRDATA = e_mem[idx];
        4'h3:    sHRDATA = n_mem[idx];
        4'h4:    sHRDATA = r_mem[idx];
        default: sHRDATA = '0;
      endcase
    end
  end

  // Exponentiation datapath; a modmul spends 2048 step cycles, then one cycle with fin set
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      op_m      <= '0;
      op_e      <= '0;
      op_n      <= '0;
      acc       <= '0;
      prod      <= '0;
      bit_idx   <= '0;
      it_idx    <= '0;
      fin       <= 1'b0;
      r_mem     <= '0;
      done_flag <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start_req) begin
            op_m      <= m_mem;
            op_e      <= e_mem;
            op_n      <= n_mem;
            acc       <= {{(W-1){1'b0}}, 1'b1};
            prod      <= '0;
            bit_idx   <= 11'd2047;
            it_idx    <= 11'd2047;
            fin       <= 1'b0;
            done_flag <= 1'b0;
          end
        end
        ST_SCAN: begin
          if (!op_e[bit_idx] && bit_idx != '0) bit_idx <= bit_idx - 11'd1;
        end
        ST_SQR, ST_MUL: begin
          if (!fin) begin
            prod <= mm_next;
            if (it_idx == '0) fin <= 1'b1;
            else              it_idx <= it_idx - 11'd1;
          end else begin
            acc    <= prod[W-1:0];
            prod   <= '0;
            it_idx <= 11'd2047;
            fin    <= 1'b0;
            if (bit_idx != '0 && (state == ST_MUL || !op_e[bit_idx]))
              bit_idx <= bit_idx - 11'd1;
          end
        end
        ST_FINISH: begin
          r_mem     <= acc;
          done_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_rsa2048_slave.sv
// Directed and randomized bench for ahb_rsa2048_slave; results compared against a
// plain repeated-multiplication model of M^E mod N.
module tb_ahb_rsa2048_slave;

  localparam logic [31:0] BASE   = 32'h7800_0000;
  localparam logic [31:0] CTRL   = BASE + 32'h000;
  localparam logic [31:0] STATUS = BASE + 32'h004;
  localparam logic [31:0] IDREG  = BASE + 32'h00C;
  localparam logic [31:0] MWIN   = BASE + 32'h100;
  localparam logic [31:0] EWIN   = BASE + 32'h200;
  localparam logic [31:0] NWIN   = BASE + 32'h300;
  localparam logic [31:0] RWIN   = BASE + 32'h400;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        sHSEL;
  logic [31:0] sHADDR;
  logic [1:0]  sHTRANS;
  logic        sHWRITE;
  logic [2:0]  sHSIZE;
  logic [2:0]  sHBURST;
  logic [31:0] sHWDATA;
  logic [31:0] sHRDATA;
  logic [1:0]  sHRESP;
  logic        sHREADYin;
  logic        sHREADYout;

  int tests = 0;
  int fails = 0;

  ahb_rsa2048_slave #(.ADDR_BITS(12)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .sHSEL(sHSEL), .sHADDR(sHADDR), .sHTRANS(sHTRANS),
    .sHWRITE(sHWRITE), .sHSIZE(sHSIZE), .sHBURST(sHBURST), .sHWDATA(sHWDATA),
    .sHRDATA(sHRDATA), .sHRESP(sHRESP), .sHREADYin(sHREADYin), .sHREADYout(sHREADYout)
  );

  always #5 HCLK = ~HCLK;

  function automatic longint model_modexp(input longint m, input longint e, input longint n);
    longint r;
    r = 1;
    for (longint k = 0; k < e; k++) r = (r * m) % n;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
    sHSEL = 1'b1; sHTRANS = 2'b10; sHWRITE = 1'b1; sHADDR = addr;
    @(posedge HCLK); #1;
    sHSEL = 1'b0; sHTRANS = 2'b00; sHWRITE = 1'b0; sHWDATA = data;
    @(posedge HCLK); #1;
  endtask

  task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
    sHSEL = 1'b1; sHTRANS = 2'b10; sHWRITE = 1'b0; sHADDR = addr;
    @(posedge HCLK); #1;
    sHSEL = 1'b0; sHTRANS = 2'b00;
    data = sHRDATA;
    @(posedge HCLK); #1;
  endtask

  task automatic load_ops(input logic [31:0] m, input logic [31:0] e, input logic [31:0] n);
    for (int k = 0; k < 64; k++) begin
      bus_write(MWIN + 32'(4 * k), (k == 0) ? m : 32'd0);
      bus_write(EWIN + 32'(4 * k), (k == 0) ? e : 32'd0);
      bus_write(NWIN + 32'(4 * k), (k == 0) ? n : 32'd0);
    end
  endtask

  task automatic wait_done(input string tag);
    logic [31:0] s;
    int polls;
    polls = 0;
    s = '0;
    do begin
      bus_read(STATUS, s);
      polls++;
    end while (!s[1] && polls < 20000);
    check(tag, s, 32'h2);
    if (!s[1]) $fatal(1, "FAIL %s: engine did not finish within poll budget", tag);
  endtask

  initial begin
    logic [31:0] rd;
    logic [31:0] rm, re, rn;
    longint      exp_r;

    HRESET = 1'b1; sHSEL = 1'b0; sHADDR = '0; sHTRANS = 2'b00; sHWRITE = 1'b0;
    sHSIZE = 3'b010; sHBURST = 3'b000; sHWDATA = '0; sHREADYin = 1'b1;
    repeat (3) @(posedge HCLK);
    #1;
    check("reset_rdata", sHRDATA, 32'h0);
    check("reset_ready", {31'd0, sHREADYout}, 32'h1);
    check("reset_resp", {30'd0, sHRESP}, 32'h0);
    HRESET = 1'b0;

    bus_read(STATUS, rd); check("status_after_reset", rd, 32'h0);
    bus_read(IDREG, rd);  check("id", rd, 32'h5253_4132);
    bus_read(RWIN, rd);   check("r0_after_reset", rd, 32'h0);
    bus_read(CTRL, rd);   check("ctrl_reads_zero", rd, 32'h0);

    // 4^13 mod 497 with ignored writes while busy
    load_ops(32'd4, 32'd13, 32'd497);
    bus_write(CTRL, 32'h1);
    bus_read(STATUS, rd); check("status_busy", rd, 32'h1);
    bus_write(MWIN, 32'd7);
    bus_write(CTRL, 32'h1);
    bus_read(MWIN, rd); check("m0_write_ignored_busy", rd, 32'd4);
    check("ready_busy", {31'd0, sHREADYout}, 32'h1);
    check("resp_busy", {30'd0, sHRESP}, 32'h0);
    wait_done("done_run1");
    exp_r = model_modexp(4, 13, 497);
    bus_read(RWIN, rd); check("r0_run1", rd, 32'(exp_r));
    for (int k = 1; k < 64; k++) begin
      bus_read(RWIN + 32'(4 * k), rd);
      check("r_upper_run1", rd, 32'h0);
    end

    // 2^10 mod 1000, then E = 0
    load_ops(32'd2, 32'd10, 32'd1000);
    bus_write(CTRL, 32'h1);
    bus_read(STATUS, rd); check("status_done_cleared", rd, 32'h1);
    wait_done("done_run2");
    bus_read(RWIN, rd); check("r0_run2", rd, 32'(model_modexp(2, 10, 1000)));
    bus_write(EWIN, 32'd0);
    bus_write(CTRL, 32'h1);
    wait_done("done_e0");
    bus_read(RWIN, rd); check("r0_e0", rd, 32'(model_modexp(2, 0, 1000)));

    // N window pattern, read-only R, unmapped locations, back-to-back write/read
    for (int k = 0; k < 64; k++) bus_write(NWIN + 32'(4 * k), 32'hA5A5_0000 + 32'(k));
    for (int k = 0; k < 64; k++) begin
      bus_read(NWIN + 32'(4 * k), rd);
      check("n_pattern", rd, 32'hA5A5_0000 + 32'(k));
    end
    bus_write(RWIN + 32'h14, 32'hDEAD_BEEF);
    bus_read(RWIN + 32'h14, rd); check("r5_readonly", rd, 32'h0);
    bus_write(BASE + 32'h500, 32'h1234_5678);
    bus_read(BASE + 32'h500, rd); check("unmapped_500", rd, 32'h0);
    bus_read(BASE + 32'h008, rd); check("unmapped_008", rd, 32'h0);
    sHSEL = 1'b1; sHTRANS = 2'b10; sHWRITE = 1'b1; sHADDR = MWIN + 32'h0C;
    @(posedge HCLK); #1;
    sHWDATA = 32'hC0FF_EE01; sHWRITE = 1'b0;
    @(posedge HCLK); #1;
    sHSEL = 1'b0; sHTRANS = 2'b00;
    check("b2b_write_read", sHRDATA, 32'hC0FF_EE01);
    @(posedge HCLK); #1;

    // Reset in the middle of a run
    load_ops(32'd4, 32'd13, 32'd497);
    bus_write(CTRL, 32'h1);
    repeat (100) @(posedge HCLK);
    #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    bus_read(STATUS, rd); check("status_after_abort", rd, 32'h0);
    bus_read(MWIN, rd);   check("m0_after_abort", rd, 32'h0);
    bus_read(EWIN, rd);   check("e0_after_abort", rd, 32'h0);
    bus_read(NWIN, rd);   check("n0_after_abort", rd, 32'h0);
    bus_read(RWIN, rd);   check("r0_after_abort", rd, 32'h0);
    load_ops(32'd4, 32'd13, 32'd497);
    bus_write(CTRL, 32'h1);
    wait_done("done_fresh");
    bus_read(RWIN, rd); check("r0_fresh", rd, 32'(model_modexp(4, 13, 497)));

    // Randomized small operands satisfying N > 1 and M < N
    rn = $urandom_range(65535, 2);
    rm = $urandom % rn;
    re = $urandom_range(15, 1);
    load_ops(rm, re, rn);
    bus_write(CTRL, 32'h1);
    wait_done("done_random");
    exp_r = model_modexp(longint'(rm), longint'(re), longint'(rn));
    bus_read(RWIN, rd);       check("r0_random", rd, 32'(exp_r));
    bus_read(RWIN + 32'h4, rd); check("r1_random", rd, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
